pmsm_dq_plant: RTL and testbench

//  Parametrised fixed-point PMSM plant model for HIL: discrete-time forward-Euler

---
 rtl/pmsm_dq_plant.sv | 182 ++++++++++++++++++
 tb/tb_pmsm_dq_plant.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pmsm_dq_plant.sv
// rtl/pmsm_dq_plant.sv - fixed-point PMSM dq plant, forward-Euler step per start pulse
// One shared signed multiplier, sequenced by a 15-state FSM; all state outputs commit together.
module pmsm_dq_plant #(
  parameter int W          = 16,
  parameter int FRAC       = 12,
  parameter int ANGLE_W    = 16,
  parameter int POLE_PAIRS = 4,
  parameter int G_I        = 410,
  parameter int R_Q        = 4096,
  parameter int L_Q        = 410,
  parameter int PSI_Q      = 205,
  parameter int KT_Q       = 1229,
  parameter int G_W        = 41,
  parameter int B_Q        = 0,
  parameter int G_TH       = 41
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic signed [W-1:0]  v_d,
  input  logic signed [W-1:0]  v_q,
  input  logic signed [W-1:0]  t_load,
  output logic                 busy,
  output logic                 done,
  output logic                 sat,
  output logic signed [W-1:0]  i_d,
  output logic signed [W-1:0]  i_q,
  output logic signed [W-1:0]  torque,
  output logic signed [W-1:0]  omega_m,
  output logic [ANGLE_W-1:0]   theta_e
);

  localparam logic [3:0] S_IDLE   = 4'd0,  S_WE = 4'd1,  S_LWE = 4'd2,  S_D1 = 4'd3,
                         S_D2     = 4'd4,  S_D3 = 4'd5,  S_Q1  = 4'd6,  S_Q2 = 4'd7,
                         S_Q3     = 4'd8,  S_Q4 = 4'd9,  S_TE  = 4'd10, S_W1 = 4'd11,
                         S_W2     = 4'd12, S_TH = 4'd13, S_COMMIT = 4'd14;

  localparam logic signed [W-1:0] K_P   = W'(POLE_PAIRS);
  localparam logic signed [W-1:0] K_GI  = W'(G_I);
  localparam logic signed [W-1:0] K_R   = W'(R_Q);
  localparam logic signed [W-1:0] K_L   = W'(L_Q);
  localparam logic signed [W-1:0] K_PSI = W'(PSI_Q);
  localparam logic signed [W-1:0] K_KT  = W'(KT_Q);
  localparam logic signed [W-1:0] K_GW  = W'(G_W);
  localparam logic signed [W-1:0] K_B   = W'(B_Q);
  localparam logic signed [W-1:0] K_GTH = W'(G_TH);

  logic [3:0]           state;
  logic signed [W-1:0]  vd_r, vq_r, tl_r;
  logic signed [W-1:0]  we, lwe, acc, idn, iqn, te, wn;
  logic [ANGLE_W-1:0]   thn;
  logic                 sat_acc;

  logic signed [W-1:0]   mul_a, mul_b, term, res;
  logic signed [2*W-1:0] prod, shifted, term_wide, sum_wide;
  logic signed [W+1:0]   x0, x1, tx, sum;
  logic                  neg, term_ovf, res_ovf;

  // Out of range when the bits above the W-bit sign position disagree.
  function automatic logic ovf(input logic signed [2*W-1:0] x);
    return !((&x[2*W-1:W-1]) || !(|x[2*W-1:W-1]));
  endfunction

  function automatic logic signed [W-1:0] clip(input logic signed [2*W-1:0] x);
    if (ovf(x))
      return x[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return x[W-1:0];
  endfunction

  function automatic logic signed [W+1:0] ext(input logic signed [W-1:0] x);
    return {{2{x[W-1]}}, x};
  endfunction

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    x0    = '0;
    x1    = '0;
    neg   = 1'b0;
    case (state)
      S_WE:  begin mul_a = K_P;   mul_b = omega_m; end
      S_LWE: begin mul_a = K_L;   mul_b = we; end
      S_D1:  begin mul_a = K_R;   mul_b = i_d; x0 = ext(vd_r); neg = 1'b1; end
      S_D2:  begin mul_a = lwe;   mul_b = i_q; x0 = ext(acc); end
      S_D3:  begin mul_a = K_GI;  mul_b = acc; x0 = ext(i_d); end
      S_Q1:  begin mul_a = K_R;   mul_b = i_q; x0 = ext(vq_r); neg = 1'b1; end
      S_Q2:  begin mul_a = lwe;   mul_b = i_d; x0 = ext(acc); neg = 1'b1; end
      S_Q3:  begin mul_a = K_PSI; mul_b = we;  x0 = ext(acc); neg = 1'b1; end
      S_Q4:  begin mul_a = K_GI;  mul_b = acc; x0 = ext(i_q); end
      S_TE:  begin mul_a = K_KT;  mul_b = iqn; end
      S_W1:  begin mul_a = K_B;   mul_b = omega_m; x0 = ext(te); x1 = -ext(tl_r); neg = 1'b1; end
      S_W2:  begin mul_a = K_GW;  mul_b = acc; x0 = ext(omega_m); end
      S_TH:  begin mul_a = K_GTH; mul_b = wn; end
      default: ;
    endcase
  end

  // Pole-pair scaling is an integer product, so WE bypasses the fractional shift.
  always_comb begin
    prod      = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
    shifted   = prod >>> FRAC;
    term_wide = (state == S_WE) ? prod : shifted;
    term_ovf  = ovf(term_wide);
    term      = clip(term_wide);
    tx        = neg ? -ext(term) : ext(term);
    sum       = x0 + x1 + tx;
    sum_wide  = {{(W-2){sum[W+1]}}, sum};
    res_ovf   = ovf(sum_wide);
    res       = clip(sum_wide);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sat     <= 1'b0;
      i_d     <= '0;
      i_q     <= '0;
      torque  <= '0;
      omega_m <= '0;
      theta_e <= '0;
      vd_r    <= '0;
      vq_r    <= '0;
      tl_r    <= '0;
      we      <= '0;
      lwe     <= '0;
      acc     <= '0;
      idn     <= '0;
      iqn     <= '0;
      te      <= '0;
      wn      <= '0;
      thn     <= '0;
      sat_acc <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vd_r    <= v_d;
            vq_r    <= v_q;
            tl_r    <= t_load;
            sat_acc <= 1'b0;
            busy    <= 1'b1;
            state   <= S_WE;
          end
        end
        // Angle increment wraps modulo one electrical turn and never saturates.
        S_TH: begin
          thn   <= theta_e + shifted[ANGLE_W-1:0];
          state <= S_COMMIT;
        end
        S_COMMIT: begin
          i_d     <= idn;
          i_q     <= iqn;
          torque  <= te;
          omega_m <= wn;
          theta_e <= thn;
          sat     <= sat_acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          sat_acc <= sat_acc | term_ovf | res_ovf;
          state   <= state + 4'd1;
          case (state)
            S_WE:  we  <= res;
            S_LWE: lwe <= res;
            S_D1, S_D2, S_Q1, S_Q2, S_Q3, S_W1: acc <= res;
            S_D3:  idn <= res;
            S_Q4:  iqn <= res;
            S_TE:  te  <= res;
            S_W2:  wn  <= res;
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmsm_dq_plant.sv
// tb/tb_pmsm_dq_plant.sv - randomized bench for pmsm_dq_plant against an integer reference model
module tb_pmsm_dq_plant;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start = 1'b0;
  logic signed [15:0] v_d = '0, v_q = '0, t_load = '0;

  logic               busy_o [3];
  logic               done_o [3];
  logic               sat_o  [3];
  logic signed [15:0] id_o   [3];
  logic signed [15:0] iq_o   [3];
  logic signed [15:0] tq_o   [3];
  logic signed [15:0] om_o   [3];
  logic [15:0]        th_o   [3];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (done_o[0]) done_cnt <= done_cnt + 1;

  pmsm_dq_plant u_dut (
    .clk(clk), .nrst(nrst), .start(start), .v_d(v_d), .v_q(v_q), .t_load(t_load),
    .busy(busy_o[0]), .done(done_o[0]), .sat(sat_o[0]), .i_d(id_o[0]), .i_q(iq_o[0]),
    .torque(tq_o[0]), .omega_m(om_o[0]), .theta_e(th_o[0]));

  pmsm_dq_plant #(.PSI_Q(0), .KT_Q(0)) u_nopm (
    .clk(clk), .nrst(nrst), .start(start), .v_d(v_d), .v_q(v_q), .t_load(t_load),
    .busy(busy_o[1]), .done(done_o[1]), .sat(sat_o[1]), .i_d(id_o[1]), .i_q(iq_o[1]),
    .torque(tq_o[1]), .omega_m(om_o[1]), .theta_e(th_o[1]));

  pmsm_dq_plant #(.G_W(4096), .KT_Q(0), .G_TH(4096)) u_fast (
    .clk(clk), .nrst(nrst), .start(start), .v_d(v_d), .v_q(v_q), .t_load(t_load),
    .busy(busy_o[2]), .done(done_o[2]), .sat(sat_o[2]), .i_d(id_o[2]), .i_q(iq_o[2]),
    .torque(tq_o[2]), .omega_m(om_o[2]), .theta_e(th_o[2]));

  longint p_kt  [3] = '{1229, 0, 0};
  longint p_psi [3] = '{205, 205, 205};
  longint p_gw  [3] = '{41, 41, 4096};
  longint p_gth [3] = '{41, 41, 4096};

  longint m_id [3], m_iq [3], m_te [3], m_om [3], m_th [3];
  longint m_sat [3];
  bit     f_sat;

  initial p_psi[1] = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint satv(input longint x);
    if (x > 32767) begin f_sat = 1'b1; return 32767; end
    if (x < -32768) begin f_sat = 1'b1; return -32768; end
    return x;
  endfunction

  function automatic longint tq(input longint a, input longint b);
    return satv((a * b) >>> 12);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_id[k] = 0; m_iq[k] = 0; m_te[k] = 0; m_om[k] = 0; m_th[k] = 0; m_sat[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input longint vd, input longint vq, input longint tl);
    longint we, lwe, a, b, c, idn, iqn, te, wn;
    f_sat = 1'b0;
    we  = satv(4 * m_om[k]);
    lwe = tq(410, we);
    a   = satv(vd - tq(4096, m_id[k]));
    a   = satv(a + tq(lwe, m_iq[k]));
    idn = satv(m_id[k] + tq(410, a));
    b   = satv(vq - tq(4096, m_iq[k]));
    b   = satv(b - tq(lwe, m_id[k]));
    b   = satv(b - tq(p_psi[k], we));
    iqn = satv(m_iq[k] + tq(410, b));
    te  = tq(p_kt[k], iqn);
    c   = satv(te - tl - tq(0, m_om[k]));
    wn  = satv(m_om[k] + tq(p_gw[k], c));
    m_th[k] = (m_th[k] + ((p_gth[k] * wn) >>> 12)) & 65535;
    m_id[k] = idn; m_iq[k] = iqn; m_te[k] = te; m_om[k] = wn;
    m_sat[k] = f_sat ? 1 : 0;
  endtask

  task automatic compare_all(input longint exp_done);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("i_d[%0d]", k), id_o[k], m_id[k]);
      check($sformatf("i_q[%0d]", k), iq_o[k], m_iq[k]);
      check($sformatf("torque[%0d]", k), tq_o[k], m_te[k]);
      check($sformatf("omega[%0d]", k), om_o[k], m_om[k]);
      check($sformatf("theta[%0d]", k), th_o[k], m_th[k]);
      check($sformatf("sat[%0d]", k), sat_o[k], m_sat[k]);
      check($sformatf("done[%0d]", k), done_o[k], exp_done);
      check($sformatf("busy[%0d]", k), busy_o[k], 0);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic run_step(input int vd, input int vq, input int tl, input bit mid);
    int n;
    v_d = 16'(vd); v_q = 16'(vq); t_load = 16'(tl); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy_o[0], 1);
    n = 0;
    while (!done_o[0] && n < 40) begin
      @(negedge clk);
      n++;
      if (mid && n == 4) begin
        start = 1'b1; v_d = 16'($urandom); v_q = 16'($urandom); t_load = 16'($urandom);
      end
      if (mid && n == 5) start = 1'b0;
    end
    check("done_latency", n, 14);
    for (int k = 0; k < 3; k++) model_step(k, vd, vq, tl);
    compare_all(1);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 2) != 0) r = 16'($signed($urandom_range(0, 4095)) - 2048);
    return int'(r);
  endfunction

  initial begin
    int d0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all(0);
    nrst = 1'b1;
    @(negedge clk);

    run_step(0, 0, 0, 0);
    check("zero_i_d", id_o[0], 0);
    check("zero_omega", om_o[0], 0);
    check("zero_sat", sat_o[0], 0);

    do_reset();
    run_step(4096, 0, 0, 0);
    check("nopm_i_d", id_o[1], 410);
    check("nopm_i_q", iq_o[1], 0);
    check("nopm_omega", om_o[1], 0);
    check("nopm_sat", sat_o[1], 0);

    do_reset();
    run_step(0, 0, -16384, 0);
    check("fast_omega", om_o[2], 16384);
    check("fast_theta", th_o[2], 16384);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      run_step(0, 0, 0, 0);
    end
    check("fast_theta_wrap", th_o[2], 0);
    check("fast_omega_hold", om_o[2], 16384);

    do_reset();
    run_step(0, 0, -32768, 0);
    check("omega_sat_val", om_o[2], 32767);
    check("omega_sat_flag", sat_o[2], 1);

    do_reset();
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 1) != 0) @(negedge clk);
      run_step(rnd16(), rnd16(), rnd16(), 0);
    end

    @(negedge clk);
    d0 = done_cnt;
    run_step(rnd16(), rnd16(), rnd16(), 1);
    run_step(rnd16(), rnd16(), rnd16(), 0);
    repeat (20) @(negedge clk);
    check("done_count_mid_start", done_cnt - d0, 2);

    v_d = 16'($urandom); v_q = 16'($urandom); t_load = 16'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    nrst = 1'b0;
    #1;
    model_reset();
    compare_all(0);
    d0 = done_cnt;
    @(negedge clk);
    nrst = 1'b1;
    repeat (25) @(negedge clk);
    check("no_done_after_abort", done_cnt - d0, 0);
    run_step(rnd16(), rnd16(), rnd16(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
